// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the request legality check applied when a request is accepted.
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_BAD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        DONE,
        FAULT
    } lsu_state_e;

    // A request is illegal if its size code is unused, it is misaligned for
    // its size, or it falls outside the populated memory.
    function automatic logic req_illegal(input logic [1:0]  size,
                                         input logic [31:0] addr,
                                         input logic [31:0] mem_bytes);
        logic bad;
        bad = 1'b0;
        if (size == SIZE_BAD)
            bad = 1'b1;
        if (size == SIZE_HALF && addr[0] != 1'b0)
            bad = 1'b1;
        if (size == SIZE_WORD && addr[1:0] != 2'b00)
            bad = 1'b1;
        if (addr >= mem_bytes)
            bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte/half lane steering: extracts and extends load data from a bus word and
// merges sub-word store data into a previously read bus word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] st_data,
    output logic [31:0] ld_val,
    output logic [31:0] st_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        sign_fill;

    always_comb begin
        byte_lane = word[{addr_lo, 3'b000} +: 8];
        half_lane = addr_lo[1] ? word[31:16] : word[15:0];
        sign_fill = 1'b0;
        ld_val    = word;
        st_word   = st_data;
        case (size)
            SIZE_BYTE: begin
                sign_fill = ~is_unsigned & byte_lane[7];
                ld_val    = {{24{sign_fill}}, byte_lane};
                st_word   = word;
                st_word[{addr_lo, 3'b000} +: 8] = st_data[7:0];
            end
            SIZE_HALF: begin
                sign_fill = ~is_unsigned & half_lane[15];
                ld_val    = {{16{sign_fill}}, half_lane};
                st_word   = addr_lo[1] ? {st_data[15:0], word[15:0]}
                                       : {word[31:16], st_data[15:0]};
            end
            default: begin
                ld_val  = word;
                st_word = st_data;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: one request at a time over a req/ack word bus,
// sub-word stores by read-modify-write, per-phase ack timeout into sticky FAULT.
//
//   state | meaning
//   IDLE  | waiting for start; request latched and checked here
//   RD    | bus read phase (loads and sub-word stores)
//   WR    | bus write phase (merged word or full store word)
//   DONE  | one-cycle completion pulse
//   FAULT | illegal request or bus timeout; held until reset
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 4096,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        write,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        busy,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);
    localparam logic [7:0]  WAIT_LAST = 8'(TIMEOUT - 1);

    lsu_state_e  state_q, state_d;
    logic        write_q, write_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  wait_q, wait_d;

    logic [31:0] ld_val;
    logic [31:0] st_word;
    logic        timed_out;

    lsu_align u_align (
        .word        (bus_rdata),
        .addr_lo     (addr_q[1:0]),
        .size        (op_q[1:0]),
        .is_unsigned (op_q[2]),
        .st_data     (wdata_q),
        .ld_val      (ld_val),
        .st_word     (st_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            op_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            wait_q  <= 8'h0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wait_q  <= wait_d;
        end
    end

    // Last allowed wait cycle of a phase: no ack here means FAULT next.
    assign timed_out = (wait_q == WAIT_LAST);

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wait_d  = 8'h0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    write_d = write;
                    op_d    = op;
                    addr_d  = addr;
                    wdata_d = wdata;
                    if (req_illegal(op[1:0], addr, MEM_LIMIT))
                        state_d = FAULT;
                    else if (write && op[1:0] == SIZE_WORD)
                        state_d = WR;
                    else
                        state_d = RD;
                end
            end
            RD: begin
                if (bus_ack) begin
                    if (write_q) begin
                        wdata_d = st_word;
                        state_d = WR;
                    end else begin
                        rdata_d = ld_val;
                        state_d = DONE;
                    end
                end else if (timed_out) begin
                    state_d = FAULT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            WR: begin
                if (bus_ack)
                    state_d = DONE;
                else if (timed_out)
                    state_d = FAULT;
                else
                    wait_d = wait_q + 8'd1;
            end
            DONE: begin
                state_d = IDLE;
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus_req   = (state_q == RD) || (state_q == WR);
    assign bus_we    = (state_q == WR);
    assign bus_addr  = {addr_q[31:2], 2'b00};
    assign bus_wdata = wdata_q;
    assign rdata     = rdata_q;
    assign done      = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign fault     = (state_q == FAULT);

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected
// completions and bus phases; a negedge monitor pops and compares them.
module tb_load_store_unit;

    typedef struct {
        logic        is_fault;
        logic [31:0] rd;
        int          cyc;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        int          len;
    } bexp_t;

    logic        clk;
    logic        reset;
    logic        start, start_t;
    logic        write;
    logic [2:0]  op;
    logic [31:0] addr, wdata;
    logic [31:0] rdata, rdata_t;
    logic        done, busy, fault, done_t, busy_t, fault_t;
    logic        bus_req, bus_we, bus_req_t, bus_we_t;
    logic [31:0] bus_addr, bus_wdata, bus_addr_t, bus_wdata_t;
    logic [31:0] bus_rdata, bus_rdata_t;
    logic        bus_ack, bus_ack_t;

    logic [31:0] mem [0:1023];
    int          ack_delay;
    logic        ack_en, ack_t_en;
    int          wcnt;
    int          cyc = 0;

    int vec = 0;
    int bad = 0;

    exp_t  sb[$];
    bexp_t bq[$];

    int          run = 0;
    logic [31:0] addr0;
    logic        unstable = 1'b0;
    int          req_cnt = 0;
    int          done_cnt = 0;
    logic        chk_busy_next = 1'b0;
    logic        fault_prev = 1'b0;

    load_store_unit dut (
        .clk(clk), .reset(reset), .start(start), .write(write), .op(op),
        .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .busy(busy),
        .fault(fault), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    load_store_unit #(.MEM_BYTES(4096), .TIMEOUT(4)) dut_t (
        .clk(clk), .reset(reset), .start(start_t), .write(write), .op(op),
        .addr(addr), .wdata(wdata), .rdata(rdata_t), .done(done_t), .busy(busy_t),
        .fault(fault_t), .bus_req(bus_req_t), .bus_we(bus_we_t), .bus_addr(bus_addr_t),
        .bus_wdata(bus_wdata_t), .bus_rdata(bus_rdata_t), .bus_ack(bus_ack_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus responder: acks after ack_delay wait cycles of a phase.
    assign bus_ack     = bus_req && ack_en && (wcnt == ack_delay);
    assign bus_rdata   = mem[bus_addr[11:2]];
    assign bus_ack_t   = bus_req_t && ack_t_en;
    assign bus_rdata_t = 32'h1234_5678;

    always @(posedge clk) begin
        if (reset || !bus_req || bus_ack)
            wcnt <= 0;
        else
            wcnt <= wcnt + 1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t  e;
        bexp_t b;
        req_cnt += int'(bus_req);
        if (bus_req) begin
            if (run == 0)
                addr0 = bus_addr;
            else if (bus_addr !== addr0)
                unstable = 1'b1;
            run++;
            if (bus_ack) begin
                check("bus_phase_expected", 32'(bq.size() != 0), 32'd1);
                if (bq.size() != 0) begin
                    b = bq.pop_front();
                    check("bus_we", 32'(bus_we), 32'(b.we));
                    check("bus_addr", bus_addr, b.addr);
                    if (b.we)
                        check("bus_wdata", bus_wdata, b.wd);
                    check("bus_phase_len", 32'(run), 32'(b.len));
                    check("bus_addr_stable", 32'(unstable), 32'd0);
                end
                run      = 0;
                unstable = 1'b0;
            end
        end else begin
            run      = 0;
            unstable = 1'b0;
        end

        if (done) begin
            done_cnt++;
            chk_busy_next = 1'b1;
            check("done_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("done_not_fault", 32'(e.is_fault), 32'd0);
                check("done_cycle", 32'(cyc), 32'(e.cyc));
                check("rdata", rdata, e.rd);
            end
        end else if (chk_busy_next) begin
            chk_busy_next = 1'b0;
            check("busy_after_done", 32'(busy), 32'd0);
        end

        if (fault && !fault_prev) begin
            check("fault_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("fault_kind", 32'(e.is_fault), 32'd1);
                check("fault_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        fault_prev = fault;
    end

    task automatic exp_bus(input logic we, input logic [31:0] a, input logic [31:0] wd, input int len);
        bexp_t b;
        b.we = we; b.addr = a; b.wd = wd; b.len = len;
        bq.push_back(b);
    endtask

    task automatic issue(input logic w, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] wd, input int lat, input logic exp_f,
                         input logic [31:0] exp_rd);
        exp_t e;
        @(negedge clk);
        write = w; op = o; addr = a; wdata = wd; start = 1'b1;
        e.is_fault = exp_f; e.rd = exp_rd; e.cyc = cyc + lat;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_sb();
        for (int i = 0; i < 64; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check("completion_within_budget", 32'(sb.size()), 32'd0);
        check("bus_phases_consumed", 32'(bq.size()), 32'd0);
        sb.delete();
        bq.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_rdata"}, rdata, 32'h0);
        check({nm, "_done"}, 32'(done), 32'd0);
        check({nm, "_busy"}, 32'(busy), 32'd0);
        check({nm, "_fault"}, 32'(fault), 32'd0);
        check({nm, "_bus_req"}, 32'(bus_req), 32'd0);
        check({nm, "_bus_we"}, 32'(bus_we), 32'd0);
        check({nm, "_bus_addr"}, bus_addr, 32'h0);
        check({nm, "_bus_wdata"}, bus_wdata, 32'h0);
    endtask

    task automatic fault_vec(input logic [2:0] o, input logic [31:0] a, input string nm);
        int r0;
        r0 = req_cnt;
        issue(1'b0, o, a, 32'h0, 1, 1'b1, 32'h0);
        repeat (5) @(negedge clk);
        check({nm, "_held"}, 32'({fault, busy}), 32'd3);
        check({nm, "_no_bus_req"}, 32'(req_cnt - r0), 32'd0);
        check({nm, "_sb_empty"}, 32'(sb.size()), 32'd0);
        sb.delete();
        do_reset();
        check({nm, "_cleared"}, 32'({fault, busy}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, reqc, ff, c0;
        logic found;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[4]    = 32'h80FF_7F01;
        mem[8]    = 32'h1122_3344;
        mem[1023] = 32'hCAFE_F00D;
        reset = 1'b1; start = 1'b0; start_t = 1'b0; write = 1'b0; op = 3'b000;
        addr = 32'h0; wdata = 32'h0; ack_en = 1'b1; ack_delay = 0; ack_t_en = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;

        // Loads from 0x80FF7F01 at 0x10
        exp_bus(1'b0, 32'h10, 32'h0, 1);
        issue(1'b0, 3'b000, 32'h13, 32'h0, 2, 1'b0, 32'hFFFF_FF80);
        wait_sb();
        exp_bus(1'b0, 32'h10, 32'h0, 1);
        issue(1'b0, 3'b100, 32'h13, 32'h0, 2, 1'b0, 32'h0000_0080);
        wait_sb();
        exp_bus(1'b0, 32'h10, 32'h0, 1);
        issue(1'b0, 3'b001, 32'h12, 32'h0, 2, 1'b0, 32'hFFFF_80FF);
        wait_sb();
        exp_bus(1'b0, 32'h10, 32'h0, 1);
        issue(1'b0, 3'b101, 32'h10, 32'h0, 2, 1'b0, 32'h0000_7F01);
        wait_sb();
        exp_bus(1'b0, 32'h10, 32'h0, 1);
        issue(1'b0, 3'b000, 32'h11, 32'h0, 2, 1'b0, 32'h0000_007F);
        wait_sb();

        // Stores: rdata keeps the last load value
        exp_bus(1'b0, 32'h20, 32'h0, 1);
        exp_bus(1'b1, 32'h20, 32'hABCD_3344, 1);
        issue(1'b1, 3'b001, 32'h22, 32'h0000_ABCD, 3, 1'b0, 32'h0000_007F);
        wait_sb();
        exp_bus(1'b0, 32'h20, 32'h0, 1);
        exp_bus(1'b1, 32'h20, 32'h1122_5A44, 1);
        issue(1'b1, 3'b000, 32'h21, 32'hFFFF_FF5A, 3, 1'b0, 32'h0000_007F);
        wait_sb();
        exp_bus(1'b1, 32'h30, 32'hDEAD_BEEF, 1);
        issue(1'b1, 3'b010, 32'h30, 32'hDEAD_BEEF, 2, 1'b0, 32'h0000_007F);
        wait_sb();

        // Last word of memory
        exp_bus(1'b0, 32'hFFC, 32'h0, 1);
        issue(1'b0, 3'b010, 32'hFFC, 32'h0, 2, 1'b0, 32'hCAFE_F00D);
        wait_sb();

        // Five wait states
        ack_delay = 5;
        exp_bus(1'b0, 32'h20, 32'h0, 6);
        issue(1'b0, 3'b010, 32'h20, 32'h0, 7, 1'b0, 32'h1122_3344);
        wait_sb();

        // Start pulsed while busy is ignored
        ack_delay = 2;
        d0 = done_cnt;
        exp_bus(1'b0, 32'h10, 32'h0, 3);
        issue(1'b0, 3'b010, 32'h10, 32'h0, 4, 1'b0, 32'h80FF_7F01);
        write = 1'b1; op = 3'b010; addr = 32'h20; wdata = 32'h5555_5555; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_sb();
        repeat (4) @(negedge clk);
        check("busy_start_single_done", 32'(done_cnt - d0), 32'd1);
        ack_delay = 0;

        // Reset in the middle of a read phase
        ack_en = 1'b0;
        @(negedge clk);
        write = 1'b0; op = 3'b010; addr = 32'h10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("mid_rd_bus_req", 32'(bus_req), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("mid_rd");
        ack_en = 1'b1;

        // Illegal requests
        fault_vec(3'b010, 32'h6,    "misaligned_word");
        fault_vec(3'b001, 32'h3,    "misaligned_half");
        fault_vec(3'b011, 32'h0,    "bad_size");
        fault_vec(3'b010, 32'h1000, "out_of_range");

        // Timeout on the TIMEOUT=4 instance
        @(negedge clk);
        write = 1'b0; op = 3'b010; addr = 32'h40; start_t = 1'b1;
        @(negedge clk);
        start_t = 1'b0;
        check("to_bus_addr", bus_addr_t, 32'h40);
        check("to_bus_we", 32'(bus_we_t), 32'd0);
        reqc = 0; ff = 0;
        for (int k = 1; k <= 8; k++) begin
            if (bus_req_t) reqc++;
            if (fault_t && ff == 0) ff = k;
            @(negedge clk);
        end
        check("to_req_cycles", 32'(reqc), 32'd4);
        check("to_fault_cycle", 32'(ff), 32'd5);
        check("to_fault_busy_held", 32'({fault_t, busy_t}), 32'd3);
        do_reset();
        check("to_reset_clear", 32'({fault_t, busy_t}), 32'd0);
        check("to_reset_wdata", bus_wdata_t, 32'h0);
        ack_t_en = 1'b1;
        @(negedge clk);
        start_t = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start_t = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (done_t && !found) begin
                found = 1'b1;
                check("to_reload_latency", 32'(cyc - c0), 32'd2);
                check("to_reload_rdata", rdata_t, 32'h1234_5678);
            end
            @(negedge clk);
        end
        check("to_reload_done_seen", 32'(found), 32'd1);

        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit that sits directly downstream of the core's memory-access stage and replaces its direct word-only memory port. It accepts one access request, checks alignment and range, and performs the word-wide bus transactions over a req/ack handshake with variable wait states. Sub-word stores are done as read-modify-write. The unit returns zero- or sign-extended load data.

## Interface
- `MEM_BYTES`, 4096 — size of the addressable memory in bytes; any access with `addr >= MEM_BYTES` faults.
- `TIMEOUT`, 255 — maximum cycles to wait for `bus_ack` in one bus phase before faulting; the range is 1..255.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request strobe; sampled only in IDLE.
- `write`  in  1  1 = store, 0 = load.
- `op`  in  3  bit [2]: unsigned load (zero-extend). Bits [1:0]: 00 byte, 01 half, 10 word, 11 invalid.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data; low byte or half is used for sub-word stores.
- `rdata`  out  32  extended load data; holds its value until the next load completes.
- `done`  out  1  one-cycle completion pulse.
- `busy`  out  1  high in every state except IDLE.
- `fault`  out  1  sticky; cleared only by reset.
- `bus_req`  out  1  bus request.
- `bus_we`  out  1  bus write enable.
- `bus_addr`  out  32  word address, equal to `{addr[31:2], 2'b00}`.
- `bus_wdata`  out  32  full word to write.
- `bus_rdata`  in  32  read word; valid when `bus_ack` is high.
- `bus_ack`  in  1  transaction complete.

## Operation
- **IDLE.** When `start` is high, latch `write`, `op`, `addr` and `wdata`, then check the request. Any of the following goes to FAULT:
  - `op[1:0]==11`;
  - a half access with `addr[0]!=0`;
  - a word access with `addr[1:0]!=0`;
  - `addr >= MEM_BYTES`.
- **IDLE, valid request.** A load or a sub-word store goes to RD. A word store goes to WR.
- **RD.** Drive `bus_req=1`, `bus_we=0`. On `bus_ack`, capture `bus_rdata`:
  - For a load, extract the byte lane (`addr[1:0]`) or half lane (`addr[1]`), little-endian. Extend with zeros if `op[2]` is 1, otherwise with the sign bit. Write the result to `rdata` and go to DONE.
  - For a store, merge the new byte or half into the captured word and go to WR.
- **WR.** Drive `bus_req=1`, `bus_we=1`, `bus_wdata` = the merged word (or `wdata` for a word store). On `bus_ack` go to DONE.
- **DONE.** `done=1` for exactly this cycle, then go to IDLE.
- **FAULT.** `fault=1` and `busy=1`. The unit stays here until reset. `bus_req` is 0.
- **Timeout.** The wait counter clears on every entry to RD or WR. It increments on each cycle in RD or WR without `bus_ack`. When it reaches `TIMEOUT` without an ack, the next state is FAULT.
- **Bus stability.** `bus_addr`, `bus_we` and `bus_wdata` are stable while `bus_req` is high. `bus_ack` is ignored when `bus_req` is low.
- **Ignored start.** `start` outside IDLE is ignored; no queuing.

## Timing
- **Reset values.** State IDLE. `rdata=0`, `done=0`, `busy=0`, `fault=0`, `bus_req=0`, `bus_we=0`, `bus_addr=0`, `bus_wdata=0`, wait counter 0. Reset wins over any other event, including mid-transaction; an outstanding bus phase is abandoned.
- **Latency with zero wait states**, where `start` is sampled at edge t and `bus_ack` is high in the first request cycle:
  - load or word store: `done` high in cycle t+2;
  - sub-word store: `done` high in cycle t+3.
- Each wait cycle adds one cycle per bus phase.
- `bus_req` is asserted in the cycle right after the `start` edge.
- **Next start.** `busy` falls in the cycle after DONE. A new `start` may be sampled in that IDLE cycle.
- **Faulting start.** `fault` and `busy` rise in the cycle after the faulting `start` edge. No bus request is issued.
- **Timeout.** With `TIMEOUT=N` and no ack, the bus phase lasts N cycles. FAULT is entered at the next edge.

## Structure
- Shared package `lsu_pkg`: size encodings (`SIZE_BYTE`, `SIZE_HALF`, `SIZE_WORD`) and the state enum (IDLE, RD, WR, DONE, FAULT).
- Sub-module `lsu_align`: purely combinational.
  - Inputs: word, `addr[1:0]`, size, unsigned flag, store data.
  - Outputs: extended load value and merged store word.
  - The FSM, the counter and the handshake stay in `load_store_unit`.

## Test plan
- **Byte load, signed and unsigned.** Memory word at 0x10 = 0x80FF7F01.
  - `op=000`, addr 0x13 → `rdata=0xFFFFFF80`.
  - `op=100`, addr 0x13 → `rdata=0x00000080`.
  - Both with `done` at t+2.
- **Half store read-modify-write.** Word 0x11223344 at 0x20; `op=001`, addr 0x22, `wdata=0x0000ABCD`.
  - Bus shows a read at 0x20, then a write of 0xABCD3344.
  - `done` at t+3.
- **Wait states.** Word load with `bus_ack` delayed 5 cycles.
  - `bus_req` and `bus_addr` are stable for 6 cycles.
  - `done` at t+7.
- **Misalignment and range.** Each of the following:
  - word access at 0x6;
  - half access at 0x3;
  - `op[1:0]=11`;
  - addr 0x1000 with `MEM_BYTES=4096`.
  - Each gives `fault=1` at t+1, no `bus_req` ever, and `fault` held until reset.
- **Timeout.** `TIMEOUT=4`, no ack.
  - `bus_req` high for 4 cycles, then `fault=1`.
  - Reset clears `fault` and `busy`, and the unit accepts a new load normally.
- **Reset mid-transaction and busy start.**
  - Reset during RD → all outputs at their reset values on the next cycle.
  - `start` pulsed while busy → ignored, exactly one `done`.
